// File: rtl/bloom_filter_core.sv
// Bloom filter datapath: K multiplicative hashes over an M_BITS flop array with insert/check/clear.
// Optional insert statistics counter enabled by defining BLOOM_STATS_EN.
module bloom_filter_core #(
    parameter int DATA_W = 32,
    parameter int M_BITS = 256,
    parameter int K_HASH = 3,
    parameter int CLR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic              rsp_match,
    output logic              rsp_err,
    output logic [15:0]       ins_count
);

    localparam int IDX_W   = $clog2(M_BITS);
    localparam int N_CHUNK = M_BITS / CLR_W;
    localparam int PTR_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CHUNK - 1);

    localparam logic [1:0] OP_INSERT = 2'b00;
    localparam logic [1:0] OP_CHECK  = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HASH   = 2'b01,
        ST_LOOKUP = 2'b10,
        ST_CLEAR  = 2'b11
    } state_e;

    function automatic logic [31:0] hash_const(input int k);
        logic [31:0] c;
        case (k)
            0:       c = 32'h9E37_79B1;
            1:       c = 32'h85EB_CA77;
            2:       c = 32'hC2B2_AE3D;
            3:       c = 32'h27D4_EB2F;
            default: c = 32'h9E37_79B1;
        endcase
        return c;
    endfunction

    // Index is the top IDX_W bits of the truncated product.
    function automatic logic [IDX_W-1:0] hash_idx(input logic [DATA_W-1:0] key,
                                                  input logic [31:0]       c);
        logic [DATA_W-1:0] prod;
        prod = key * DATA_W'(c);
        return IDX_W'(prod >> (DATA_W - IDX_W));
    endfunction

    state_e                        state_q, state_d;
    logic [DATA_W-1:0]             key_q, key_d;
    logic                          is_ins_q, is_ins_d;
    logic [K_HASH-1:0][IDX_W-1:0]  idx_q, idx_d;
    logic [PTR_W-1:0]              ptr_q, ptr_d;
    logic [M_BITS-1:0]             bits_q, bits_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic                          rsp_match_q, rsp_match_d;
    logic                          rsp_err_q, rsp_err_d;
    logic                          hit_s;

    // Next-state, array update and response generation.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        is_ins_d    = is_ins_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        bits_d      = bits_q;
        rsp_valid_d = 1'b0;
        rsp_match_d = 1'b0;
        rsp_err_d   = 1'b0;
        hit_s       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_INSERT, OP_CHECK: begin
                            key_d    = req_data;
                            is_ins_d = (req_op == OP_INSERT);
                            state_d  = ST_HASH;
                        end
                        OP_CLEAR: begin
                            ptr_d   = '0;
                            state_d = ST_CLEAR;
                        end
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HASH: begin
                for (int k = 0; k < K_HASH; k++) begin
                    idx_d[k] = hash_idx(key_q, hash_const(k));
                end
                state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                // Match is taken from pre-update array contents (test-and-set).
                for (int k = 0; k < K_HASH; k++) begin
                    hit_s = hit_s & bits_q[idx_q[k]];
                end
                if (is_ins_q) begin
                    for (int k = 0; k < K_HASH; k++) begin
                        bits_d[idx_q[k]] = 1'b1;
                    end
                end else begin
                    bits_d = bits_q;
                end
                rsp_valid_d = 1'b1;
                rsp_match_d = hit_s;
                state_d     = ST_IDLE;
            end
            ST_CLEAR: begin
                bits_d[int'(ptr_q)*CLR_W +: CLR_W] = '0;
                if (ptr_q == PTR_LAST) begin
                    ptr_d       = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, array and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            is_ins_q    <= 1'b0;
            idx_q       <= '0;
            ptr_q       <= '0;
            bits_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_match_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            is_ins_q    <= is_ins_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            bits_q      <= bits_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_match_q <= rsp_match_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_match = rsp_match_q;
    assign rsp_err   = rsp_err_q;

`ifdef BLOOM_STATS_EN
    logic [15:0] ins_cnt_q, ins_cnt_d;

    // Saturating count of completed inserts; a finished clear restarts it.
    always_comb begin
        ins_cnt_d = ins_cnt_q;
        if (state_q == ST_CLEAR && ptr_q == PTR_LAST) begin
            ins_cnt_d = 16'h0000;
        end else if (state_q == ST_LOOKUP && is_ins_q && ins_cnt_q != 16'hFFFF) begin
            ins_cnt_d = ins_cnt_q + 16'h0001;
        end else begin
            ins_cnt_d = ins_cnt_q;
        end
    end

    // Insert counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ins_cnt_q <= 16'h0000;
        end else begin
            ins_cnt_q <= ins_cnt_d;
        end
    end

    assign ins_count = ins_cnt_q;
`else
    assign ins_count = 16'h0000;
`endif

endmodule

// File: tb/tb_bloom_filter_core.sv
// Scoreboard bench for bloom_filter_core (M_BITS=256, K_HASH=3, CLR_W=32).
// Expected responses are queued at issue time and checked by an independent monitor.
module tb_bloom_filter_core;

    typedef struct {
        logic       m;
        logic       e;
        int         cyc;
        logic [1:0] op;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_match;
    logic        rsp_err;
    logic [15:0] ins_count;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   sb_cnt = 0;

    bloom_filter_core dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_match (rsp_match),
        .rsp_err   (rsp_err),
        .ins_count (ins_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cnt_exp();
`ifdef BLOOM_STATS_EN
        return (sb_cnt > 65535) ? 65535 : sb_cnt;
`else
        return 0;
`endif
    endfunction

    // Monitor: pops one expectation per response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("rsp_match op%0d", e.op), int'(rsp_match), int'(e.m));
                    chk($sformatf("rsp_err op%0d", e.op), int'(rsp_err), int'(e.e));
                    chk($sformatf("rsp_cycle op%0d", e.op), cyc, e.cyc);
                end
            end else if (rsp_match || rsp_err) begin
                chk("idle_flags", int'({rsp_match, rsp_err}), 0);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] data,
                         input logic exp_m, input logic exp_e, input bit want_rsp);
        int   w;
        int   lat;
        exp_t e;
        w = 0;
        while (!req_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
        end
        lat = (op == 2'b10) ? 9 : ((op == 2'b11) ? 1 : 3);
        if (want_rsp) begin
            e.m = exp_m; e.e = exp_e; e.cyc = cyc + lat; e.op = op;
            exp_q.push_back(e);
        end
        if (op == 2'b00) sb_cnt++;
        if (op == 2'b10) sb_cnt = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((!req_ready || exp_q.size() != 0) && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) chk("idle_timeout", 0, 1);
    endtask

    task automatic check_cnt(input string name);
        wait_idle();
        chk(name, int'(ins_count), cnt_exp());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", int'(req_ready), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_ins_count", int'(ins_count), 0);

        // Empty array, then key 0 (indices 0,0,0).
        issue(2'b01, 32'h0, 1'b0, 1'b0, 1'b1);
        issue(2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
        issue(2'b01, 32'h0, 1'b1, 1'b0, 1'b1);
        issue(2'b00, 32'h0, 1'b1, 1'b0, 1'b1);

        // Key 1 (indices 0x9E, 0x85, 0xC2).
        issue(2'b01, 32'h1, 1'b0, 1'b0, 1'b1);
        issue(2'b00, 32'h1, 1'b0, 1'b0, 1'b1);
        issue(2'b01, 32'h1, 1'b1, 1'b0, 1'b1);
        check_cnt("count_after_inserts");

        // Clear: busy for 8 cycles, then both keys absent.
        issue(2'b10, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("clear_busy_%0d", i), int'(req_ready), 0);
            @(negedge clk);
        end
        chk("clear_ready_back", int'(req_ready), 1);
        issue(2'b01, 32'h0, 1'b0, 1'b0, 1'b1);
        issue(2'b01, 32'h1, 1'b0, 1'b0, 1'b1);
        check_cnt("count_after_clear");

        // Reserved op leaves the array alone.
        issue(2'b00, 32'h1, 1'b0, 1'b0, 1'b1);
        issue(2'b11, 32'h1, 1'b0, 1'b1, 1'b1);
        issue(2'b01, 32'h1, 1'b1, 1'b0, 1'b1);
        issue(2'b11, 32'h0, 1'b0, 1'b1, 1'b1);
        issue(2'b01, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset during CLEAR cycle 4: no response, array fully zeroed.
        issue(2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        issue(2'b10, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        sb_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("midclr_ready", int'(req_ready), 1);
        chk("midclr_ins_count", int'(ins_count), 0);
        issue(2'b01, 32'h1, 1'b0, 1'b0, 1'b1);
        issue(2'b01, 32'h0, 1'b0, 1'b0, 1'b1);

        // Statistics: three inserts, then saturation.
        issue(2'b00, 32'h2, 1'b0, 1'b0, 1'b1);
        issue(2'b00, 32'h3, 1'b0, 1'b0, 1'b1);
        issue(2'b00, 32'h4, 1'b0, 1'b0, 1'b1);
        check_cnt("count_three");
`ifdef BLOOM_STATS_EN
        force dut.ins_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.ins_cnt_q;
        sb_cnt = 65535;
        issue(2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
        check_cnt("count_saturate");
`endif

        repeat (12) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
